// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the sequenced shifter.
package shift_seq_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_e;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: shifts by 2^idx when enabled, with op-dependent fill.
module shift_stage import shift_seq_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  localparam int SHAMT_W = $clog2(XLEN),
  localparam int IDX_W = $clog2(SHAMT_W + 1)
) (
  input  logic [XLEN-1:0]  i_data,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  input  logic [1:0]       i_op,
  input  logic             i_sign,
  output logic [XLEN-1:0]  o_data
);

  logic [SHAMT_W-1:0] amt;
  logic [XLEN-1:0]    fill_mask;

  always_comb begin
    amt       = i_en ? (SHAMT_W'(1) << i_idx) : '0;
    fill_mask = ~({XLEN{1'b1}} >> amt);
    if (i_op == SHIFT_SLL) begin
      o_data = i_data << amt;
    end else if (i_op == SHIFT_SRA) begin
      o_data = (i_data >> amt) | (i_sign ? fill_mask : '0);
    end else begin
      // reserved 2'b10 falls through to a logical right shift
      o_data = i_data >> amt;
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: applies one barrel-shift level per cycle under a valid/ready handshake.
//   state | meaning
//   IDLE  | ready to accept; stage 0 is applied on the accept edge
//   SHIFT | applying stage idx_q each edge
//   DONE  | result valid, held until i_ready
module shift_seq_unit import shift_seq_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_op,
  input  logic [XLEN-1:0]    i_operand_a,
  input  logic [SHAMT_W-1:0] i_operand_b,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_result,
  output logic               o_busy
);

  localparam int IDX_W = $clog2(SHAMT_W + 1);

  shift_state_e       state_q, state_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;

  logic               in_idle;
  logic [XLEN-1:0]    cur_data;
  logic [IDX_W-1:0]   cur_idx;
  logic [SHAMT_W-1:0] cur_shamt;
  logic [SHAMT_W-1:0] shamt_at_idx;
  logic [SHAMT_W-1:0] shamt_rem;
  logic [1:0]         cur_op;
  logic               cur_sign;
  logic [IDX_W-1:0]   idx_next;
  logic [XLEN-1:0]    stage_out;
  logic               last_stage;

  // In IDLE the single stage operates on the raw inputs so stage 0 lands on the accept edge.
  always_comb begin
    in_idle      = (state_q == IDLE);
    cur_data     = in_idle ? i_operand_a : data_q;
    cur_idx      = in_idle ? '0 : idx_q;
    cur_shamt    = in_idle ? i_operand_b : shamt_q;
    cur_op       = in_idle ? i_op : op_q;
    cur_sign     = in_idle ? i_operand_a[XLEN-1] : sign_q;
    idx_next     = cur_idx + IDX_W'(1);
    shamt_at_idx = cur_shamt >> cur_idx;
    shamt_rem    = cur_shamt >> idx_next;
    last_stage   = (idx_next == IDX_W'(SHAMT_W)) || (EARLY_EXIT && (shamt_rem == '0));
  end

  shift_stage #(.XLEN(XLEN)) u_stage (
    .i_data (cur_data),
    .i_idx  (cur_idx),
    .i_en   (shamt_at_idx[0]),
    .i_op   (cur_op),
    .i_sign (cur_sign),
    .o_data (stage_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_d    = i_op;
            shamt_d = i_operand_b;
            sign_d  = i_operand_a[XLEN-1];
            data_d  = stage_out;
            idx_d   = idx_next;
            state_d = last_stage ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_d  = stage_out;
          idx_d   = idx_next;
          state_d = last_stage ? DONE : SHIFT;
        end
        DONE: begin
          if (i_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q != IDLE);
  assign o_result = data_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit; a second instance runs with EARLY_EXIT=0.
module tb_shift_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        valid, valid_ne;
  logic        flush;
  logic        ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  b;

  logic        ready_o, valid_o, busy_o;
  logic [31:0] result_o;
  logic        ready_o_ne, valid_o_ne, busy_o_ne;
  logic [31:0] result_o_ne;

  int tests;
  int fails;

  shift_seq_unit #(.XLEN(32), .EARLY_EXIT(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_o),
    .i_op(op), .i_operand_a(a), .i_operand_b(b), .i_flush(flush),
    .o_valid(valid_o), .i_ready(ready), .o_result(result_o), .o_busy(busy_o)
  );

  shift_seq_unit #(.XLEN(32), .EARLY_EXIT(1'b0)) dut_ne (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_ne), .o_ready(ready_o_ne),
    .i_op(op), .i_operand_a(a), .i_operand_b(b), .i_flush(flush),
    .o_valid(valid_o_ne), .i_ready(ready), .o_result(result_o_ne), .o_busy(busy_o_ne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
  task automatic issue(input bit ne, input logic [1:0] t_op, input logic [31:0] t_a,
                       input logic [4:0] t_b);
    op = t_op; a = t_a; b = t_b;
    if (ne) valid_ne = 1'b1; else valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; valid_ne = 1'b0;
  endtask

  // Counts edges from the accept edge (edge 1) until o_valid is seen, bounded.
  task automatic wait_valid(input bit ne, output int n);
    n = 1;
    while (((ne ? valid_o_ne : valid_o) == 1'b0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b result=%h ready=%b, want 0 0 00000000 1",
               valid_o, busy_o, result_o, ready_o);
    end
    #10 rst_n = 1'b1;
    step();
    tests++;
    if (ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: ready=%b want 1", ready_o);
    end
  endtask

  task automatic test_sll_max();
    int n, busy_cnt;
    logic [31:0] res;
    n = 0; busy_cnt = 0; res = '0;
    issue(1'b0, 2'b00, 32'h0000_0001, 5'd31);
    for (int k = 1; k <= 20; k++) begin
      if (valid_o && n == 0) begin
        n = k;
        res = result_o;
      end
      if (busy_o) busy_cnt++;
      else break;
      step();
    end
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL sll31_latency: got %0d want 5", n);
    end
    tests++;
    if (res !== 32'h8000_0000) begin
      fails++;
      $display("FAIL sll31_result: got %h want 80000000", res);
    end
    tests++;
    if (busy_cnt !== 5) begin
      fails++;
      $display("FAIL sll31_busy_cycles: got %0d want 5", busy_cnt);
    end
  endtask

  task automatic test_right_shifts();
    int n;
    issue(1'b0, 2'b11, 32'h8000_0000, 5'd4);
    wait_valid(1'b0, n);
    tests++;
    if (n !== 3 || result_o !== 32'hF800_0000) begin
      fails++;
      $display("FAIL sra4: latency %0d result %h, want 3 f8000000", n, result_o);
    end
    step();
    issue(1'b0, 2'b01, 32'h8000_0000, 5'd4);
    wait_valid(1'b0, n);
    tests++;
    if (n !== 3 || result_o !== 32'h0800_0000) begin
      fails++;
      $display("FAIL srl4: latency %0d result %h, want 3 08000000", n, result_o);
    end
    step();
    issue(1'b1, 2'b11, 32'h8000_0000, 5'd4);
    wait_valid(1'b1, n);
    tests++;
    if (n !== 5 || result_o_ne !== 32'hF800_0000) begin
      fails++;
      $display("FAIL sra4_noearly: latency %0d result %h, want 5 f8000000", n, result_o_ne);
    end
    step();
    issue(1'b1, 2'b01, 32'h8000_0000, 5'd4);
    wait_valid(1'b1, n);
    tests++;
    if (n !== 5 || result_o_ne !== 32'h0800_0000) begin
      fails++;
      $display("FAIL srl4_noearly: latency %0d result %h, want 5 08000000", n, result_o_ne);
    end
    step();
  endtask

  task automatic test_zero_and_reserved();
    int n;
    issue(1'b0, 2'b11, 32'hDEAD_BEEF, 5'd0);
    wait_valid(1'b0, n);
    tests++;
    if (n !== 1 || result_o !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL shamt0: latency %0d result %h, want 1 deadbeef", n, result_o);
    end
    step();
    issue(1'b0, 2'b10, 32'hF000_0000, 5'd4);
    wait_valid(1'b0, n);
    tests++;
    if (n !== 3 || result_o !== 32'h0F00_0000) begin
      fails++;
      $display("FAIL reserved_op: latency %0d result %h, want 3 0f000000", n, result_o);
    end
    step();
  endtask

  task automatic test_back_pressure();
    int n;
    ready = 1'b0;
    issue(1'b0, 2'b00, 32'h0000_00FF, 5'd8);
    op = 2'b11; a = 32'h1234_5678; b = 5'd31;
    wait_valid(1'b0, n);
    tests++;
    if (n !== 4 || result_o !== 32'h0000_FF00) begin
      fails++;
      $display("FAIL bp_result: latency %0d result %h, want 4 0000ff00", n, result_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (valid_o !== 1'b1 || result_o !== 32'h0000_FF00 || ready_o !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h ready=%b, want 1 0000ff00 0",
                 k, valid_o, result_o, ready_o);
      end
    end
    ready = 1'b1;
    step();
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: ready=%b valid=%b, want 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    issue(1'b0, 2'b00, 32'h0000_0001, 5'd31);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_shift: ready=%b busy=%b valid=%b, want 1 0 0", ready_o, busy_o, valid_o);
    end
    for (int k = 0; k < 6; k++) begin
      if (valid_o) seen++;
      step();
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL flush_no_valid: valid seen %0d cycles want 0", seen);
    end
    flush = 1'b1;
    valid = 1'b1; op = 2'b00; a = 32'h1; b = 5'd3;
    step();
    flush = 1'b0; valid = 1'b0;
    tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL flush_idle_accept: busy=%b ready=%b, want 0 1", busy_o, ready_o);
    end
  endtask

  task automatic test_async_reset();
    int n;
    issue(1'b0, 2'b00, 32'h0000_0001, 5'd31);
    step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: valid=%b busy=%b result=%h ready=%b, want 0 0 00000000 1",
               valid_o, busy_o, result_o, ready_o);
    end
    #2 rst_n = 1'b1;
    step();
    issue(1'b0, 2'b11, 32'hFFFF_FFF0, 5'd2);
    wait_valid(1'b0, n);
    tests++;
    if (n !== 2 || result_o !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL post_reset_sra: latency %0d result %h, want 2 fffffffc", n, result_o);
    end
    step();
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; valid = 1'b0; valid_ne = 1'b0; flush = 1'b0; ready = 1'b1;
    op = 2'b00; a = '0; b = '0;
    test_reset();
    test_sll_max();
    test_right_shifts();
    test_zero_and_reserved();
    test_back_pressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
Multi-cycle sequenced shifter for the execute stage: a controller that drives one barrel-shift stage per cycle instead of a full 5-level combinational shifter. Executes SLL/SRL/SRA on XLEN-bit operands with a valid/ready handshake to the pipeline, supports an optional early exit once the remaining shift-amount bits are zero, and supports a pipeline flush that aborts the operation.

Parameters:
XLEN, 32, operand/result width
SHAMT_W, $clog2(XLEN) (derived, not overridable), shift-amount width and number of stages
EARLY_EXIT, 1, 1 = finish as soon as the remaining shamt bits are all zero; 0 = always run all SHAMT_W stages

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  unit can accept; equals (state == IDLE)
i_op  in  2  shift op: SLL=2'b00, SRL=2'b01, SRA=2'b11; 2'b10 reserved, executes as SRL
i_operand_a  in  XLEN  data to shift
i_operand_b  in  SHAMT_W  shift amount
i_flush  in  1  synchronous kill, highest priority
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_result  out  XLEN  shifted data
o_busy  out  1  state != IDLE (drives stall logic)

Behaviour:
- Reset (i_rst_n low, asynchronous): state = IDLE, data register = 0, stage index = 0, latched shamt/op = 0, o_valid = 0, o_result = 0, o_busy = 0, o_ready = 1 after release.
- FSM states: IDLE, SHIFT, DONE.
- Accept: i_valid & o_ready & !i_flush at a rising edge.
  - On that edge, latch op, shamt, and sign = i_operand_a[XLEN-1].
  - Load the data register with i_operand_a with stage 0 already applied (shift by 1 if shamt[0]).
  - Stage index becomes 1.
- Stage k: if shamt[k] is set, shift by 2^k.
  - SLL: fill with zeros from the LSB side.
  - SRL: fill with zeros from the MSB side.
  - SRA: fill with the latched sign bit.
  - If shamt[k] is clear, data passes unchanged.
- SHIFT: on each edge apply stage[index], then index++.
- Exit condition, evaluated on the accept edge and on every SHIFT edge, after the stage is applied:
  - the next index == SHAMT_W, or
  - EARLY_EXIT=1 and shamt[SHAMT_W-1:next index] == 0.
  - When met, go to DONE; otherwise go to or stay in SHIFT.
- Latency: o_valid rises after edge N, counting the accept edge as edge 1.
  - EARLY_EXIT=0: N = SHAMT_W = 5.
  - EARLY_EXIT=1: N = max(1, msb_index(shamt)+1).
  - Example: shamt=0 or 1 gives N=1, 4 gives 3, 31 gives 5.
- DONE:
  - o_valid = 1, o_result = data register, held stable while i_ready is low.
  - On i_valid... no: on i_ready high at an edge, go to IDLE.
  - No accept is possible in DONE, so throughput is at most one op per N+1 cycles.
- o_result is the registered data output in all states. It is meaningful only when o_valid is high and keeps its last value otherwise.
- Flush: i_flush high at an edge forces IDLE from any state.
  - o_valid is low the next cycle and the in-flight result is discarded.
  - i_flush with i_valid in IDLE means no accept.
  - i_flush with i_ready in DONE still goes to IDLE; the consumer treats that result as killed.
- Input changes after accept have no effect; only latched values are used.
- Reset asserted mid-operation aborts immediately to the reset values above.

Decomposition:
- Package shift_seq_pkg holds:
  - typedef enum logic [1:0] shift_op_e {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b11}
  - typedef enum logic [1:0] shift_state_e {IDLE, SHIFT, DONE}
  - localparam XLEN_DEFAULT = 32
- One sub-module, shift_stage: combinational. Inputs are data, stage index, enable bit, op and sign. Output is data shifted by 2^index with the correct fill. It is instantiated once, with a dynamic index.

Test Plan:
1. SLL, a=0x0000_0001, b=31, EARLY_EXIT=1, i_ready=1 -> o_valid after edge 5, o_result=0x8000_0000, o_busy high for 5 cycles.
2. SRA, a=0x8000_0000, b=4 -> o_valid after edge 3, o_result=0xF800_0000. The same with SRL -> 0x0800_0000. With EARLY_EXIT=0, both take 5 edges with the same values.
3. Any op, a=0xDEAD_BEEF, b=0 -> o_valid after edge 1, o_result=0xDEAD_BEEF. Then op 2'b10, a=0xF000_0000, b=4 -> 0x0F00_0000 (treated as SRL).
4. Back-pressure: SLL a=0x0000_00FF, b=8, i_ready held low 3 cycles in DONE -> o_valid stays 1, o_result stays 0x0000_FF00, o_ready stays 0. i_ready=1 -> IDLE next cycle. Inputs changed during SHIFT do not affect the result.
5. Flush: SLL b=31, i_flush pulsed on the 2nd SHIFT edge -> next cycle state IDLE, o_ready=1, o_valid never asserted. i_flush together with i_valid in IDLE -> no accept, o_busy stays 0.
6. Reset: assert i_rst_n low asynchronously mid-SHIFT -> outputs zero immediately (o_valid=0, o_busy=0). After release, a fresh SRA a=0xFFFF_FFF0, b=2 -> 0xFFFF_FFFC.
